// File: rtl/ex_advint_pipe.sv
// Advanced integer execute unit: MUL_STAGES-deep multiplier and WIDTH+2 cycle radix-2 divider behind one dispatch port.
// Commit stall freezes the output and mul pipe; EX_ADVINT_DIV_FASTPATH_EN enables the 2-cycle trivial-divide path.
module ex_advint_pipe #(
  parameter int WIDTH      = 64,
  parameter int RN_W       = 6,
  parameter int MUL_STAGES = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             ex_enable,
  output logic             ex_busy,
  input  logic [RN_W-1:0]  rd_in_rn,
  input  logic [RN_W-1:0]  rd2_in_rn,
  input  logic [2:0]       unit,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out2,
  output logic [RN_W-1:0]  rd_out_rn,
  output logic [RN_W-1:0]  rd2_out_rn,
  output logic             valid,
  input  logic             stall
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int LAST  = MUL_STAGES - 1;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_ITER,
    DIV_FIX,
    DIV_DONE
  } div_state_e;

  logic             valid_q;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] out2_q;
  logic [RN_W-1:0]  rd_out_q;
  logic [RN_W-1:0]  rd2_out_q;

  div_state_e       div_state_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             dz_q;
  logic [RN_W-1:0]  div_rd_q;
  logic [RN_W-1:0]  div_rd2_q;

  logic [MUL_STAGES-1:0] mul_vld_q;
  logic [2*WIDTH-1:0]    mul_prod_q [MUL_STAGES];
  logic [RN_W-1:0]       mul_rd_q   [MUL_STAGES];
  logic [RN_W-1:0]       mul_rd2_q  [MUL_STAGES];

  logic adv;
  logic accept;
  logic acc_mul;
  logic acc_div;
  logic sgn;

  assign adv     = !(valid_q && stall);
  assign ex_busy = (div_state_q != DIV_IDLE) || !adv;
  assign accept  = ex_enable && !ex_busy;
  assign acc_mul = accept && (unit == 3'd0);
  assign acc_div = accept && (unit == 3'd1);
  assign sgn     = op[0];

  logic unused_op_rsvd;
  assign unused_op_rsvd = &{1'b0, op[1]};

  // Product is formed at dispatch; the stage registers give retiming room to spread the array.
  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;
  logic [2*WIDTH-1:0] prod_d;

  assign a_ext  = {{WIDTH{sgn & in1[WIDTH-1]}}, in1};
  assign b_ext  = {{WIDTH{sgn & in2[WIDTH-1]}}, in2};
  assign prod_d = a_ext * b_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      mul_vld_q <= '0;
    end else if (adv) begin
      mul_vld_q[0] <= acc_mul;
      for (int i = 1; i < MUL_STAGES; i++) begin
        mul_vld_q[i] <= mul_vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      mul_prod_q[0] <= prod_d;
      mul_rd_q[0]   <= rd_in_rn;
      mul_rd2_q[0]  <= rd2_in_rn;
      for (int i = 1; i < MUL_STAGES; i++) begin
        mul_prod_q[i] <= mul_prod_q[i-1];
        mul_rd_q[i]   <= mul_rd_q[i-1];
        mul_rd2_q[i]  <= mul_rd2_q[i-1];
      end
    end
  end

  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic [WIDTH:0]   rem_sh;
  logic             step_take;
  logic [WIDTH-1:0] rem_sub;
  logic [WIDTH-1:0] rem_step;
  logic [WIDTH-1:0] quo_step;
  logic             div_take;

  assign a_neg = sgn & in1[WIDTH-1];
  assign b_neg = sgn & in2[WIDTH-1];
  assign a_mag = a_neg ? -in1 : in1;
  assign b_mag = b_neg ? -in2 : in2;

  // Restoring step: the partial remainder stays below the divisor, so the subtract fits in WIDTH bits.
  assign rem_sh    = {rem_q, quo_q[WIDTH-1]};
  assign step_take = rem_sh >= {1'b0, dvs_q};
  assign rem_sub   = rem_sh[WIDTH-1:0] - dvs_q;
  assign rem_step  = step_take ? rem_sub : rem_sh[WIDTH-1:0];
  assign quo_step  = {quo_q[WIDTH-2:0], step_take};

  assign div_take = (div_state_q == DIV_DONE) && adv && !mul_vld_q[LAST];

`ifdef EX_ADVINT_DIV_FASTPATH_EN
  logic fast_d;
  assign fast_d = (in2 == '0) || (a_mag < b_mag);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      div_state_q <= DIV_IDLE;
      quo_q       <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dz_q        <= 1'b0;
      div_rd_q    <= '0;
      div_rd2_q   <= '0;
    end else begin
      case (div_state_q)
        DIV_IDLE: begin
          if (acc_div) begin
            quo_q       <= a_mag;
            rem_q       <= '0;
            dvs_q       <= b_mag;
            cnt_q       <= CNT_W'(WIDTH);
            neg_quo_q   <= a_neg ^ b_neg;
            neg_rem_q   <= a_neg;
            dz_q        <= (in2 == '0);
            div_rd_q    <= rd_in_rn;
            div_rd2_q   <= rd2_in_rn;
            div_state_q <= DIV_ITER;
`ifdef EX_ADVINT_DIV_FASTPATH_EN
            if (fast_d) begin
              quo_q       <= '0;
              rem_q       <= a_mag;
              div_state_q <= DIV_FIX;
            end
`endif
          end
        end
        DIV_ITER: begin
          quo_q <= quo_step;
          rem_q <= rem_step;
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            div_state_q <= DIV_FIX;
          end
        end
        DIV_FIX: begin
          // Divide by zero returns all ones; the signed remainder then equals the original dividend.
          quo_q       <= dz_q ? '1 : (neg_quo_q ? -quo_q : quo_q);
          rem_q       <= neg_rem_q ? -rem_q : rem_q;
          div_state_q <= DIV_DONE;
        end
        DIV_DONE: begin
          if (div_take) begin
            div_state_q <= DIV_IDLE;
          end
        end
        default: div_state_q <= DIV_IDLE;
      endcase
    end
  end

  // Multiplier wins a collision; the divider simply waits in DONE.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= 1'b0;
      out_q     <= '0;
      out2_q    <= '0;
      rd_out_q  <= '0;
      rd2_out_q <= '0;
    end else if (adv) begin
      if (mul_vld_q[LAST]) begin
        valid_q   <= 1'b1;
        out_q     <= mul_prod_q[LAST][WIDTH-1:0];
        out2_q    <= mul_prod_q[LAST][2*WIDTH-1:WIDTH];
        rd_out_q  <= mul_rd_q[LAST];
        rd2_out_q <= mul_rd2_q[LAST];
      end else if (div_take) begin
        valid_q   <= 1'b1;
        out_q     <= quo_q;
        out2_q    <= rem_q;
        rd_out_q  <= div_rd_q;
        rd2_out_q <= div_rd2_q;
      end else begin
        valid_q <= 1'b0;
      end
    end
  end

  assign valid      = valid_q;
  assign out        = out_q;
  assign out2       = out2_q;
  assign rd_out_rn  = rd_out_q;
  assign rd2_out_rn = rd2_out_q;

`ifndef SYNTHESIS
  a_no_dispatch_when_busy: assert property (@(posedge clk) disable iff (rst) !(ex_enable && ex_busy))
    else $error("ex_advint_pipe: ex_enable asserted while ex_busy");
`endif

endmodule

// File: tb/tb_ex_advint_pipe.sv
// Scoreboard bench for ex_advint_pipe at default parameters (WIDTH=64, RN_W=6, MUL_STAGES=3).
module tb_ex_advint_pipe;
  localparam int W  = 64;
  localparam int RN = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  in1 = '0;
  logic [W-1:0]  in2 = '0;
  logic          ex_enable = 1'b0;
  logic          ex_busy;
  logic [RN-1:0] rd_in_rn = '0;
  logic [RN-1:0] rd2_in_rn = '0;
  logic [2:0]    unit = '0;
  logic [1:0]    op = '0;
  logic [W-1:0]  out;
  logic [W-1:0]  out2;
  logic [RN-1:0] rd_out_rn;
  logic [RN-1:0] rd2_out_rn;
  logic          valid;
  logic          stall = 1'b0;

  always #5 clk = ~clk;

  ex_advint_pipe dut (
    .clk(clk), .rst(rst), .in1(in1), .in2(in2), .ex_enable(ex_enable), .ex_busy(ex_busy),
    .rd_in_rn(rd_in_rn), .rd2_in_rn(rd2_in_rn), .unit(unit), .op(op),
    .out(out), .out2(out2), .rd_out_rn(rd_out_rn), .rd2_out_rn(rd2_out_rn),
    .valid(valid), .stall(stall)
  );

  typedef struct packed {
    logic [W-1:0]  o;
    logic [W-1:0]  o2;
    logic [RN-1:0] rd;
    logic [RN-1:0] rd2;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;

  localparam logic [W-1:0] MIN = 64'h8000_0000_0000_0000;

  function automatic exp_t model(input logic [2:0] u, input logic [1:0] opv,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [RN-1:0] t1, input logic [RN-1:0] t2);
    exp_t e;
    logic [2*W-1:0] p;
    logic signed [2*W-1:0] sa, sb;
    longint sq, sr;
    e.rd  = t1;
    e.rd2 = t2;
    e.o   = '0;
    e.o2  = '0;
    if (u == 3'd0) begin
      if (opv[0]) begin
        sa = $signed(a);
        sb = $signed(b);
        p  = sa * sb;
      end else begin
        p = {64'd0, a} * {64'd0, b};
      end
      e.o  = p[W-1:0];
      e.o2 = p[2*W-1:W];
    end else begin
      if (b == '0) begin
        e.o  = '1;
        e.o2 = a;
      end else if (!opv[0]) begin
        e.o  = a / b;
        e.o2 = a % b;
      end else if (a == MIN && b == '1) begin
        e.o  = MIN;
        e.o2 = '0;
      end else begin
        sq   = $signed(a) / $signed(b);
        sr   = $signed(a) % $signed(b);
        e.o  = sq;
        e.o2 = sr;
      end
    end
    return e;
  endfunction

  // Every result leaving the unit (valid and not stalled) is matched against the queue in order.
  always @(negedge clk) begin
    if (!rst && valid && !stall) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result out=%h out2=%h", out, out2);
      end else begin
        mon_e = exp_q.pop_front();
        checks += 3;
        if (out !== mon_e.o) begin
          errors++; $display("FAIL sb_out got %h exp %h", out, mon_e.o);
        end
        if (out2 !== mon_e.o2) begin
          errors++; $display("FAIL sb_out2 got %h exp %h", out2, mon_e.o2);
        end
        if (rd_out_rn !== mon_e.rd || rd2_out_rn !== mon_e.rd2) begin
          errors++; $display("FAIL sb_tags got %0d/%0d exp %0d/%0d", rd_out_rn, rd2_out_rn, mon_e.rd, mon_e.rd2);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  task automatic issue_start(input logic [2:0] u, input logic [1:0] opv, input logic [W-1:0] a,
                             input logic [W-1:0] b, input logic [RN-1:0] t1, input logic [RN-1:0] t2);
    unit = u; op = opv; in1 = a; in2 = b; rd_in_rn = t1; rd2_in_rn = t2;
    ex_enable = 1'b1;
    if (u <= 3'd1) exp_q.push_back(model(u, opv, a, b, t1, t2));
  endtask

  task automatic issue(input logic [2:0] u, input logic [1:0] opv, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [RN-1:0] t1, input logic [RN-1:0] t2);
    int g = 0;
    while (ex_busy && g < 500) begin
      @(posedge clk); #1; g++;
    end
    if (ex_busy) begin
      checks++; errors++;
      $display("FAIL issue_wait busy stuck got %b exp 0", ex_busy);
    end
    issue_start(u, opv, a, b, t1, t2);
    @(posedge clk); #1;
    ex_enable = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (!valid && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!valid) n = -1;
  endtask

  task automatic settle();
    repeat (3) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    repeat (3) begin @(posedge clk); #1; end
    checks += 6;
    if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
    if (out !== '0) begin errors++; $display("FAIL reset_out got %h exp 0", out); end
    if (out2 !== '0) begin errors++; $display("FAIL reset_out2 got %h exp 0", out2); end
    if (rd_out_rn !== '0) begin errors++; $display("FAIL reset_rd got %0d exp 0", rd_out_rn); end
    if (rd2_out_rn !== '0) begin errors++; $display("FAIL reset_rd2 got %0d exp 0", rd2_out_rn); end
    if (ex_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", ex_busy); end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mul();
    int n;
    issue(3'd0, 2'b00, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd5, 6'd6);
    wait_valid(n);
    checks += 3;
    if (n !== 3) begin errors++; $display("FAIL mul_latency got %0d exp 3", n); end
    if (out !== 64'hFFFF_FFFF_FFFF_FFFE) begin errors++; $display("FAIL mul_lo got %h exp fffffffffffffffe", out); end
    if (out2 !== 64'd1) begin errors++; $display("FAIL mul_hi got %h exp 1", out2); end
    settle();
    issue(3'd0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFD, 64'd5, 6'd1, 6'd2);
    wait_valid(n);
    checks++;
    if (out2 !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL smul_hi got %h exp all ones", out2); end
    settle();
  endtask

  task automatic test_back_to_back();
    int vcnt = 0, rises = 0;
    logic prev = 1'b0;
    for (int i = 0; i < 14; i++) begin
      if (i < 8) issue_start(3'd0, 2'($urandom_range(0, 3)), {$urandom, $urandom}, {$urandom, $urandom},
                             6'(i + 10), 6'(i + 30));
      else ex_enable = 1'b0;
      @(posedge clk); #1;
      if (valid) vcnt++;
      if (valid && !prev) rises++;
      prev = valid;
    end
    ex_enable = 1'b0;
    checks += 2;
    if (vcnt !== 8) begin errors++; $display("FAIL b2b_count got %0d exp 8", vcnt); end
    if (rises !== 1) begin errors++; $display("FAIL b2b_contiguous got %0d runs exp 1", rises); end
    settle();
  endtask

  task automatic test_div();
    int n;
    int exp_lat;
    issue(3'd1, 2'b01, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 6'd7, 6'd8);
    wait_valid(n);
    checks += 3;
    if (n !== 66) begin errors++; $display("FAIL div_latency got %0d exp 66", n); end
    if (out !== 64'hFFFF_FFFF_FFFF_FFFD) begin errors++; $display("FAIL sdiv_q got %h exp -3", out); end
    if (out2 !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL sdiv_r got %h exp -1", out2); end
    settle();
    issue(3'd1, 2'b01, MIN, 64'hFFFF_FFFF_FFFF_FFFF, 6'd9, 6'd10);
    wait_valid(n);
    checks += 2;
    if (out !== MIN) begin errors++; $display("FAIL ovf_q got %h exp %h", out, MIN); end
    if (out2 !== '0) begin errors++; $display("FAIL ovf_r got %h exp 0", out2); end
    settle();
`ifdef EX_ADVINT_DIV_FASTPATH_EN
    exp_lat = 2;
`else
    exp_lat = 66;
`endif
    issue(3'd1, 2'b00, 64'h1234, 64'd0, 6'd11, 6'd12);
    wait_valid(n);
    checks += 3;
    if (n !== exp_lat) begin errors++; $display("FAIL dz_latency got %0d exp %0d", n, exp_lat); end
    if (out !== '1) begin errors++; $display("FAIL dz_q got %h exp all ones", out); end
    if (out2 !== 64'h1234) begin errors++; $display("FAIL dz_r got %h exp 1234", out2); end
    settle();
    issue(3'd1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 6'd13, 6'd14);
    wait_valid(n);
    settle();
    issue(3'd1, 2'b00, 64'd5, 64'd9, 6'd15, 6'd16);
    wait_valid(n);
    settle();
    for (int i = 0; i < 6; i++) begin
      issue(3'd1, 2'($urandom_range(0, 3)), {$urandom, $urandom}, {32'd0, $urandom} >> $urandom_range(0, 31),
            6'(i + 40), 6'(i + 50));
      wait_valid(n);
      checks++;
      if (n < 0) begin errors++; $display("FAIL rand_div_timeout got %0d exp >0", n); end
      settle();
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] held;
    issue_start(3'd0, 2'b00, 64'd10, 64'd11, 6'd1, 6'd2);
    @(posedge clk); #1;
    issue_start(3'd0, 2'b00, 64'd12, 64'd13, 6'd3, 6'd4);
    @(posedge clk); #1;
    issue_start(3'd0, 2'b00, 64'd14, 64'd15, 6'd5, 6'd6);
    @(posedge clk); #1;
    ex_enable = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (!(valid === 1'b1 && out === 64'd110)) begin errors++; $display("FAIL stall_first got %b/%0d exp 1/110", valid, out); end
    held = out;
    stall = 1'b1;
    repeat (4) begin
      @(posedge clk); #1;
      checks += 2;
      if (out !== held || valid !== 1'b1) begin errors++; $display("FAIL stall_frozen got %0d exp %0d", out, held); end
      if (ex_busy !== 1'b1) begin errors++; $display("FAIL stall_busy got %b exp 1", ex_busy); end
    end
    stall = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (!(valid === 1'b1 && out === 64'd156)) begin errors++; $display("FAIL stall_second got %b/%0d exp 1/156", valid, out); end
    @(posedge clk); #1;
    checks++;
    if (!(valid === 1'b1 && out === 64'd210)) begin errors++; $display("FAIL stall_third got %b/%0d exp 1/210", valid, out); end
    @(posedge clk); #1;
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL stall_drained got %b exp 0", valid); end
    settle();
  endtask

  task automatic test_collision();
    issue_start(3'd0, 2'b00, 64'd3, 64'd4, 6'd20, 6'd21);
    @(posedge clk); #1;
    issue_start(3'd0, 2'b01, 64'hFFFF_FFFF_FFFF_FFFE, 64'd5, 6'd22, 6'd23);
    @(posedge clk); #1;
    issue_start(3'd1, 2'b00, 64'd100, 64'd7, 6'd24, 6'd25);
    @(posedge clk); #1;
    ex_enable = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (!(valid === 1'b1 && out === 64'd12)) begin errors++; $display("FAIL coll_first got %b/%0d exp 1/12", valid, out); end
    stall = 1'b1;
    repeat (70) begin @(posedge clk); #1; end
    checks += 2;
    if (out !== 64'd12 || valid !== 1'b1) begin errors++; $display("FAIL coll_held got %0d exp 12", out); end
    if (ex_busy !== 1'b1) begin errors++; $display("FAIL coll_busy got %b exp 1", ex_busy); end
    stall = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (!(valid === 1'b1 && out === 64'hFFFF_FFFF_FFFF_FFF6)) begin errors++; $display("FAIL coll_mul_first got %b/%h exp 1/-10", valid, out); end
    @(posedge clk); #1;
    checks += 2;
    if (!(valid === 1'b1 && out === 64'd14 && out2 === 64'd2)) begin errors++; $display("FAIL coll_div_next got %b/%0d/%0d exp 1/14/2", valid, out, out2); end
    if (rd_out_rn !== 6'd24) begin errors++; $display("FAIL coll_div_tag got %0d exp 24", rd_out_rn); end
    @(posedge clk); #1;
    checks++;
    if (valid !== 1'b0) begin errors++; $display("FAIL coll_drained got %b exp 0", valid); end
    settle();
  endtask

  task automatic test_reset_mid();
    int n;
    issue(3'd1, 2'b00, 64'd1000, 64'd3, 6'd30, 6'd31);
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    checks += 2;
    if (valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid got %b exp 0", valid); end
    if (ex_busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy got %b exp 0", ex_busy); end
    rst = 1'b0;
    repeat (80) begin
      @(posedge clk); #1;
      checks++;
      if (valid !== 1'b0) begin errors++; $display("FAIL rstmid_ghost got %b exp 0", valid); end
    end
    issue(3'd1, 2'b01, 64'd1000, 64'hFFFF_FFFF_FFFF_FFFD, 6'd32, 6'd33);
    wait_valid(n);
    checks += 2;
    if (n !== 66) begin errors++; $display("FAIL rstmid_latency got %0d exp 66", n); end
    if (out !== 64'hFFFF_FFFF_FFFF_FEB3 || out2 !== 64'd1) begin errors++; $display("FAIL rstmid_result got %h/%h exp -333/1", out, out2); end
    settle();
  endtask

  task automatic test_nop();
    int vcnt = 0;
    issue(3'd2, 2'b01, 64'd9, 64'd9, 6'd1, 6'd1);
    checks++;
    if (ex_busy !== 1'b0) begin errors++; $display("FAIL nop_busy got %b exp 0", ex_busy); end
    repeat (10) begin
      @(posedge clk); #1;
      if (valid) vcnt++;
    end
    checks++;
    if (vcnt !== 0) begin errors++; $display("FAIL nop_valid got %0d cycles exp 0", vcnt); end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_back_to_back();
    test_div();
    test_stall();
    test_collision();
    test_reset_mid();
    test_nop();
    settle();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL results_missing got %0d pending exp 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ex_advint_pipe.md
Name: ex_advint_pipe

Overview:
- Parametrised next-generation Advanced Integer execute unit: pipelined multiplier plus iterative radix-2 divider behind one dispatch port.
- Sits between dispatch and commit. Returns two results per op (out/out2) with two destination tags.
- Holds results under commit stall instead of dropping them.

Parameters:
- WIDTH, 64, operand/result width in bits (>=8, even).
- RN_W, 6, register tag width.
- MUL_STAGES, 3, multiplier latency in cycles (>=1).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- in1  in  WIDTH  operand A / dividend.
- in2  in  WIDTH  operand B / divisor.
- ex_enable  in  1  dispatch request; accepted on an edge where ex_enable=1 and ex_busy=0.
- ex_busy  out  1  unit cannot accept this cycle.
- rd_in_rn  in  RN_W  primary destination tag.
- rd2_in_rn  in  RN_W  secondary destination tag.
- unit  in  3  3'd0 multiply, 3'd1 divide; others accepted as NOP (no valid produced).
- op  in  2  op[0]=1 signed, 0 unsigned; op[1] reserved (see optional feature).
- out  out  WIDTH  product low / quotient.
- out2  out  WIDTH  product high / remainder.
- rd_out_rn  out  RN_W  tag for out.
- rd2_out_rn  out  RN_W  tag for out2 (carries rd2_in_rn, not rd_in_rn).
- valid  out  1  out/out2/tags are valid.
- stall  in  1  commit cannot take the result this cycle.

Behaviour:
- Reset, synchronous, rst=1:
  - valid=0; out, out2, rd_out_rn, rd2_out_rn = 0.
  - Divider FSM to IDLE; all multiplier stage valid bits cleared.
  - In-flight ops are discarded. Reset mid-divide yields no result.
- Output register: if valid=1 and stall=1, all outputs hold unchanged. Otherwise loaded from the winning source, or valid<=0 when there is none.
- Multiplier:
  - Full 2*WIDTH product. Signed when op[0]=1, both operands two's-complement.
  - Pipeline of MUL_STAGES registers, each with valid and both tags.
  - Whole pipe advances iff NOT (valid and stall).
  - Unstalled latency: valid rises exactly MUL_STAGES edges after the accepting edge.
  - Back-to-back issue sustains 1 result/cycle.
- Divider FSM: IDLE -> ITER -> FIX -> DONE -> IDLE.
  - IDLE: on accept of unit=1, latch |in1|, |in2| (if signed), result signs, tags; counter=WIDTH; go ITER.
  - ITER: one restoring shift-subtract step per cycle; after WIDTH steps go FIX.
  - FIX: apply signs (quotient negated if signs differ; remainder takes dividend sign); go DONE.
  - DONE: transfer to output register when the output slot is free and the last multiplier stage is empty; then IDLE. The multiplier has priority on collision; the divider waits in DONE.
  - Unstalled, no-collision latency: valid rises WIDTH+2 edges after the accepting edge (the DONE-to-output transfer is one of those edges).
- Divide by zero: quotient = all ones, remainder = in1. No exception.
- Signed overflow (MIN / -1): quotient = MIN, remainder = 0.
- ex_busy = (divider FSM != IDLE) OR (valid AND stall).
- A multiply issued just before a divide always drains first when unstalled, because WIDTH+2 > MUL_STAGES.
- ex_enable while ex_busy=1 is ignored. Simulation-only check flags it as an error.
- NOP units produce no valid. Their tags are discarded.

Optional Feature:
- Macro: EX_ADVINT_DIV_FASTPATH_EN.
- Defined: in IDLE, if divisor==0, or |dividend| < |divisor| (magnitude compare), the FSM skips ITER and goes straight to FIX with quotient=0 and remainder=dividend. The divide-by-zero values are still as above.
- Fast-path unstalled latency is 2 edges after the accepting edge.
- Not defined: every divide takes WIDTH+2 edges. The fast-path logic is absent.

Test Plan:
- Unsigned mul, WIDTH=64: in1=0xFFFF_FFFF_FFFF_FFFF, in2=2, rd=5, rd2=6 -> after MUL_STAGES edges valid=1, out=0xFFFF_FFFF_FFFF_FFFE, out2=1, rd_out_rn=5, rd2_out_rn=6.
- Signed div: in1=-7, in2=2, op=1 -> valid after 66 edges; out=-3, out2=-1. Then in1=MIN, in2=-1 -> out=MIN, out2=0.
- Divide by zero: in1=0x1234, in2=0 -> out=all ones, out2=0x1234. Latency 66 edges, or 2 edges with EX_ADVINT_DIV_FASTPATH_EN.
- Three back-to-back muls while stall=1 from the first valid for 4 cycles -> outputs frozen, ex_busy=1, no result lost. After release, results appear in order on consecutive cycles.
- Divide issued while a stalled mul is in the pipe -> divider waits in DONE; mul result emitted first, divide result on the following free cycle.
- Assert rst=1 mid-ITER -> next edge valid=0, ex_busy=0. A new divide then completes normally with correct values.
